irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_ctrl.sv | 89 ++++++++
 tb/tb_irq_pending_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: edge-detects four request lines into a pending
// vector and presents the highest-priority unmasked one until acknowledged.
module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  output logic [3:0] pend,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  output logic [7:0] svc_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] req_d;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [3:0] pend_nxt;
  logic [1:0] top_id;
  logic [1:0] id_nxt;
  logic       svc;

  assign rise     = req & ~req_d;
  assign eligible = pend & ~mask;

  // Fixed priority: bit 3 wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    top_id = 2'd0;
    if (eligible[3])      top_id = 2'd3;
    else if (eligible[2]) top_id = 2'd2;
    else if (eligible[1]) top_id = 2'd1;
    else if (eligible[0]) top_id = 2'd0;
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    svc       = 1'b0;
    case (state)
      IDLE: begin
        if (eligible != 4'd0) begin
          id_nxt    = top_id;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          svc       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Set is OR-ed in after the clear, so a rise coinciding with ack keeps the bit.
  assign clr      = svc ? (4'b0001 << irq_id) : 4'd0;
  assign pend_nxt = (pend & ~clr) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_d     <= 4'd0;
      pend      <= 4'd0;
      irq_valid <= 1'b0;
      irq_id    <= 2'd0;
      svc_cnt   <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state     <= state_nxt;
      req_d     <= req;
      pend      <= pend_nxt;
      irq_valid <= (state_nxt == PRESENT);
      irq_id    <= id_nxt;
      if (svc) svc_cnt <= svc_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: reset, single request, priority,
// masking, set/clear collision, absorb/hold, and counter wrap.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [3:0] pend;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [7:0] svc_cnt;

  int n_cmp = 0;
  int n_err = 0;

  irq_pending_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .pend     (pend),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .svc_cnt  (svc_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'd0;
    mask = 4'd0;
    ack  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    mask = 4'd0;
    ack  = 1'b0;
    #3;
    n_cmp++;
    if ({pend, irq_valid, irq_id, svc_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async: pend=%b valid=%b id=%0d cnt=%0d, want all 0", pend, irq_valid, irq_id, svc_cnt);
    end
    step();
    step();
    n_cmp++;
    if ({pend, irq_valid, irq_id, svc_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_held: pend=%b valid=%b id=%0d cnt=%0d, want all 0", pend, irq_valid, irq_id, svc_cnt);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (pend !== 4'b1111 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: pend=%b valid=%b, want 1111/0", pend, irq_valid);
    end
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin
      n_err++;
      $display("FAIL reset_first_present: valid=%b id=%0d, want 1/3", irq_valid, irq_id);
    end
    // Reset mid-cycle while presenting must drop everything without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (irq_valid !== 1'b0 || pend !== 4'd0 || irq_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_in_present: valid=%b pend=%b id=%0d, want 0/0000/0", irq_valid, pend, irq_id);
    end
    req = 4'd0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    step();
    n_cmp++;
    if (pend !== 4'b0010 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pend: pend=%b valid=%b, want 0010/0", pend, irq_valid);
    end
    req = 4'd0;
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd1) begin
      n_err++;
      $display("FAIL single_present: valid=%b id=%0d, want 1/1", irq_valid, irq_id);
    end
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd1 || pend !== 4'b0010) begin
      n_err++;
      $display("FAIL single_hold: valid=%b id=%0d pend=%b, want 1/1/0010", irq_valid, irq_id, pend);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (pend !== 4'd0 || svc_cnt !== 8'd1 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_ack: pend=%b cnt=%0d valid=%b, want 0000/1/0", pend, svc_cnt, irq_valid);
    end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    req = 4'b0101;
    step();
    req = 4'd0;
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
      n_err++;
      $display("FAIL prio_first: valid=%b id=%0d, want 1/2", irq_valid, irq_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (pend !== 4'b0001 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_gap: pend=%b valid=%b, want 0001/0", pend, irq_valid);
    end
    step();
    n_cmp++;
    if (irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_idle: valid=%b, want 0", irq_valid);
    end
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
      n_err++;
      $display("FAIL prio_second: valid=%b id=%0d, want 1/0", irq_valid, irq_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (svc_cnt !== 8'd2 || pend !== 4'd0) begin
      n_err++;
      $display("FAIL prio_count: cnt=%0d pend=%b, want 2/0000", svc_cnt, pend);
    end
    step();
  endtask

  task automatic test_mask();
    do_reset();
    mask = 4'b1000;
    req  = 4'b1001;
    step();
    req = 4'd0;
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
      n_err++;
      $display("FAIL mask_first: valid=%b id=%0d, want 1/0", irq_valid, irq_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    step();
    step();
    n_cmp++;
    if (pend !== 4'b1000 || irq_valid !== 1'b0 || svc_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL mask_blocked: pend=%b valid=%b cnt=%0d, want 1000/0/1", pend, irq_valid, svc_cnt);
    end
    mask = 4'd0;
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin
      n_err++;
      $display("FAIL mask_release: valid=%b id=%0d, want 1/3", irq_valid, irq_id);
    end
    // Re-masking the presented bit must not withdraw it.
    mask = 4'b1000;
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin
      n_err++;
      $display("FAIL mask_during_present: valid=%b id=%0d, want 1/3", irq_valid, irq_id);
    end
    mask = 4'd0;
    ack  = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (pend !== 4'd0 || svc_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL mask_final: pend=%b cnt=%0d, want 0000/2", pend, svc_cnt);
    end
    step();
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'd0;
    step();
    req = 4'b0100;
    ack = 1'b1;
    step();
    req = 4'd0;
    ack = 1'b0;
    n_cmp++;
    if (pend !== 4'b0100 || irq_valid !== 1'b0 || svc_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL collide_set_wins: pend=%b valid=%b cnt=%0d, want 0100/0/1", pend, irq_valid, svc_cnt);
    end
    step();
    step();
    n_cmp++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
      n_err++;
      $display("FAIL collide_represent: valid=%b id=%0d, want 1/2", irq_valid, irq_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_absorb_hold();
    do_reset();
    mask = 4'b1111;
    req  = 4'b0001;
    step();
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    step();
    step();
    n_cmp++;
    if (pend !== 4'b0001 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL absorb_masked: pend=%b valid=%b, want 0001/0", pend, irq_valid);
    end
    // Held-high line produces no fresh rise, so after service the bit stays clear.
    mask = 4'd0;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    step();
    n_cmp++;
    if (pend !== 4'd0 || irq_valid !== 1'b0 || svc_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL hold_single_rise: pend=%b valid=%b cnt=%0d, want 0000/0/1", pend, irq_valid, svc_cnt);
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    n_cmp++;
    if (svc_cnt !== 8'd0 || pend !== 4'd0 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ack_in_idle: cnt=%0d pend=%b valid=%b, want 0/0000/0", svc_cnt, pend, irq_valid);
    end
    for (int i = 1; i <= 256; i++) begin
      req = 4'b0001;
      step();
      req = 4'd0;
      step();
      ack = 1'b1;
      step();
      // ack still high on the GAP edge must be ignored.
      step();
      ack = 1'b0;
      if (i == 255) begin
        n_cmp++;
        if (svc_cnt !== 8'd255) begin
          n_err++;
          $display("FAIL wrap_255: cnt=%0d, want 255", svc_cnt);
        end
      end
    end
    n_cmp++;
    if (svc_cnt !== 8'd0 || pend !== 4'd0 || irq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_0: cnt=%0d pend=%b valid=%b, want 0/0000/0", svc_cnt, pend, irq_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_absorb_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
